// File: rtl/jtag_dr_bank_pkg.sv
// Shared types for the JTAG data-register bank: TAP state encoding, DR width table and
// error flag bundle.
package jtag_dr_bank_pkg;

   localparam int unsigned MAX_NUM_DR = 16;
   localparam int unsigned MAX_DR_W   = 64;

   // Entries past NUM_DR are ignored by the bank.
   typedef int unsigned dr_bank_cfg_t [MAX_NUM_DR];

   typedef enum logic [3:0] {
      TapTestLogicReset,
      TapRunTestIdle,
      TapSelectDrScan,
      TapCaptureDr,
      TapShiftDr,
      TapExit1Dr,
      TapPauseDr,
      TapExit2Dr,
      TapUpdateDr,
      TapSelectIrScan,
      TapCaptureIr,
      TapShiftIr,
      TapExit1Ir,
      TapPauseIr,
      TapExit2Ir,
      TapUpdateIr
   } tap_ctrl_fsm_t;

   typedef struct packed {
      logic len_err;
      logic overrun;
   } dr_bank_err_t;

   function automatic int unsigned max_dr_w(input dr_bank_cfg_t w, input int unsigned n);
      int unsigned m;
      m = 1;
      for (int unsigned i = 0; i < MAX_NUM_DR; i++) begin
         if (i < n && w[i] > m) m = w[i];
      end
      return (m > MAX_DR_W) ? MAX_DR_W : m;
   endfunction

endpackage

// File: rtl/jtag_dr_bank_if.sv
// Parallel capture inputs and per-DR update handshake between the DR bank (master) and
// the consuming logic (slave).
interface jtag_dr_bank_if #(
   parameter int unsigned NUM_DR = 8,
   parameter int unsigned MAX_W  = 32
);

   logic [NUM_DR*MAX_W-1:0] cap_data;
   logic [NUM_DR*MAX_W-1:0] upd_data;
   logic [NUM_DR-1:0]       upd_valid;
   logic [NUM_DR-1:0]       upd_ready;

   modport master (
      input  cap_data,
      input  upd_ready,
      output upd_data,
      output upd_valid
   );

   modport slave (
      output cap_data,
      output upd_ready,
      input  upd_data,
      input  upd_valid
   );

endinterface

// File: rtl/jtag_dr_update_slot.sv
// One DR holding register with valid/ready hand-off, overrun detection and an optional
// in-place increment used for address auto-increment.
module jtag_dr_update_slot #(
   parameter int unsigned Width = 8,
   parameter int unsigned Step  = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             upd_req_i,
   input  logic [Width-1:0] upd_data_i,
   input  logic             inc_i,
   input  logic             ready_i,
   output logic [Width-1:0] data_o,
   output logic             valid_o,
   output logic             overrun_o
);

   logic [Width-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             accept;

   assign accept    = valid_q & ready_i;
   // An update colliding with an accept in the same cycle is not an overrun.
   assign overrun_o = upd_req_i & valid_q & ~ready_i;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (accept) valid_d = 1'b0;
      if (inc_i) data_d = data_q + Width'(Step);
      // A loaded update overrides a same-cycle increment.
      if (upd_req_i && !overrun_o) begin
         data_d  = upd_data_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/jtag_dr_bank.sv
// JTAG user DR bank with BYPASS, LSB-first shift path and per-DR update hand-off.
// Define JTAG_DR_AUTOINC_EN to auto-increment the ADDR DR on each accepted DATA DR update.
module jtag_dr_bank
   import jtag_dr_bank_pkg::*;
#(
   parameter int unsigned  NUM_DR       = 8,
   parameter dr_bank_cfg_t DR_W         = '{32, 32, 4, 8, 16, 1, 12, 32,
                                            1, 1, 1, 1, 1, 1, 1, 1},
   parameter int unsigned  ADDR_DR_IDX  = 0,
   parameter int unsigned  DATA_DR_IDX  = 1,
   parameter int unsigned  AUTOINC_STEP = 4,
   localparam int unsigned MAX_W        = max_dr_w(DR_W, NUM_DR),
   localparam int unsigned SEL_W        = (NUM_DR > 1) ? $clog2(NUM_DR) : 1
) (
   input  logic              tck,
   input  logic              trst,
   input  logic              tdi,
   output logic              tdo,
   input  tap_ctrl_fsm_t     tap_state,
   input  logic [SEL_W-1:0]  dr_sel,
   input  logic              dr_sel_vld,
   jtag_dr_bank_if.master    dr_if,
   input  logic              clr_err_i,
   output logic              len_err_o,
   output logic              overrun_o
);

   localparam int unsigned      CNT_W   = $clog2(MAX_W + 2);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_W + 1);

   if (ADDR_DR_IDX >= NUM_DR || DATA_DR_IDX >= NUM_DR || ADDR_DR_IDX == DATA_DR_IDX)
   begin : g_bad_cfg
      $error("jtag_dr_bank: ADDR/DATA DR index out of range or identical");
   end

   function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
      logic [MAX_W-1:0] m;
      for (int unsigned b = 0; b < MAX_W; b++) m[b] = (b < w);
      return m;
   endfunction

   logic [MAX_W-1:0]        sr_q, sr_d;
   logic                    bypass_q, bypass_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   dr_bank_err_t            err_q, err_d;
   logic                    tdo_q;

   logic [3:0]              sel_idx;
   logic                    dr_vld;
   int unsigned             cur_w;
   logic [MAX_W-1:0]        cap_sel;
   logic                    upd_state;
   logic                    upd_ok;
   logic                    len_fail;
   logic [NUM_DR-1:0]       upd_req;
   logic [NUM_DR-1:0]       ovr;
   logic [NUM_DR-1:0]       valid;
   logic [NUM_DR*MAX_W-1:0] upd_data;

   // Out-of-range indices fall back to BYPASS.
   assign sel_idx   = 4'(dr_sel);
   assign dr_vld    = dr_sel_vld && (32'(dr_sel) < NUM_DR);
   assign cur_w     = DR_W[sel_idx];
   assign cap_sel   = dr_if.cap_data[32'(dr_sel)*MAX_W +: MAX_W];
   assign upd_state = (tap_state == TapUpdateDr) && dr_vld;
   assign len_fail  = upd_state && (cnt_q != CNT_W'(cur_w));
   assign upd_ok    = upd_state && !len_fail;

   always_comb begin
      sr_d     = sr_q;
      bypass_d = bypass_q;
      cnt_d    = cnt_q;
      case (tap_state)
         TapCaptureDr: begin
            cnt_d = '0;
            if (dr_vld) sr_d = cap_sel & width_mask(cur_w);
            else        bypass_d = 1'b0;
         end
         TapShiftDr: begin
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
            if (dr_vld) begin
               sr_d = ((sr_q >> 1) & width_mask(cur_w - 1)) | (MAX_W'(tdi) << (cur_w - 1));
            end else begin
               bypass_d = tdi;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      err_d = err_q;
      if (clr_err_i) err_d = '0;
      if (len_fail)  err_d.len_err = 1'b1;
      if (|ovr)      err_d.overrun = 1'b1;
   end

   always_ff @(posedge tck) begin
      if (trst) begin
         sr_q     <= '0;
         bypass_q <= 1'b0;
         cnt_q    <= '0;
         err_q    <= '0;
      end else begin
         sr_q     <= sr_d;
         bypass_q <= bypass_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // TDO is retimed to the falling edge so the far end samples it on the next rising edge.
   always_ff @(negedge tck) begin
      if (trst) begin
         tdo_q <= 1'b0;
      end else if (tap_state == TapShiftDr || tap_state == TapExit1Dr) begin
         tdo_q <= dr_vld ? sr_q[0] : bypass_q;
      end else begin
         tdo_q <= 1'b0;
      end
   end

`ifdef JTAG_DR_AUTOINC_EN
   logic [NUM_DR-1:0] acc;
   assign acc = valid & dr_if.upd_ready;
`endif

   for (genvar i = 0; i < NUM_DR; i++) begin : g_slot
      localparam int unsigned W = DR_W[i];
      logic [W-1:0] data;
      logic         inc;

      assign upd_req[i] = upd_ok && (dr_sel == SEL_W'(i));
`ifdef JTAG_DR_AUTOINC_EN
      assign inc = (ADDR_DR_IDX == i) ? acc[DATA_DR_IDX] : 1'b0;
`else
      assign inc = 1'b0;
`endif

      jtag_dr_update_slot #(
         .Width (W),
         .Step  (AUTOINC_STEP)
      ) u_slot (
         .clk_i      (tck),
         .rst_i      (trst),
         .upd_req_i  (upd_req[i]),
         .upd_data_i (sr_q[W-1:0]),
         .inc_i      (inc),
         .ready_i    (dr_if.upd_ready[i]),
         .data_o     (data),
         .valid_o    (valid[i]),
         .overrun_o  (ovr[i])
      );

      assign upd_data[i*MAX_W +: MAX_W] = MAX_W'(data);
   end

   assign dr_if.upd_data  = upd_data;
   assign dr_if.upd_valid = valid;
   assign tdo             = tdo_q;
   assign len_err_o       = err_q.len_err;
   assign overrun_o       = err_q.overrun;

endmodule

// File: tb/tb_jtag_dr_bank.sv
// Directed bench for jtag_dr_bank: capture/shift, hand-off, length and overrun errors,
// BYPASS, reset and (with JTAG_DR_AUTOINC_EN) address auto-increment.
module tb_jtag_dr_bank;
   import jtag_dr_bank_pkg::*;

   localparam dr_bank_cfg_t TB_DR_W = '{32, 32, 4, 8, 16, 1, 12, 32,
                                        1, 1, 1, 1, 1, 1, 1, 1};

   logic          tck;
   logic          trst;
   logic          tdi;
   logic          tdo;
   tap_ctrl_fsm_t tap_state;
   logic [2:0]    dr_sel;
   logic          dr_sel_vld;
   logic          clr_err_i;
   logic          len_err_o;
   logic          overrun_o;

   int n_checks = 0;
   int n_fail   = 0;

   jtag_dr_bank_if #(.NUM_DR(8), .MAX_W(32)) dr_if ();

   jtag_dr_bank #(
      .NUM_DR (8),
      .DR_W   (TB_DR_W)
   ) dut (
      .tck        (tck),
      .trst       (trst),
      .tdi        (tdi),
      .tdo        (tdo),
      .tap_state  (tap_state),
      .dr_sel     (dr_sel),
      .dr_sel_vld (dr_sel_vld),
      .dr_if      (dr_if),
      .clr_err_i  (clr_err_i),
      .len_err_o  (len_err_o),
      .overrun_o  (overrun_o)
   );

   initial tck = 1'b0;
   always #5 tck = ~tck;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   // One TCK cycle in the given TAP state; tdo is sampled after the falling edge.
   task automatic cycle(input tap_ctrl_fsm_t st, input logic d, output logic t);
      tap_state = st;
      tdi       = d;
      @(negedge tck);
      #1;
      t = tdo;
      @(posedge tck);
      #1;
   endtask

   task automatic run_dr(input logic [2:0] sel, input logic vld, input logic [31:0] val,
                         input int nbits, input logic [7:0] rdy_upd, input logic clr_upd,
                         output logic [31:0] tdo_bits);
      logic t;
      tdo_bits   = '0;
      dr_sel     = sel;
      dr_sel_vld = vld;
      cycle(TapCaptureDr, 1'b0, t);
      for (int k = 0; k < nbits; k++) begin
         cycle(TapShiftDr, val[k], t);
         tdo_bits[k] = t;
      end
      cycle(TapExit1Dr, 1'b0, t);
      dr_if.upd_ready = rdy_upd;
      clr_err_i       = clr_upd;
      cycle(TapUpdateDr, 1'b0, t);
      dr_if.upd_ready = '0;
      clr_err_i       = 1'b0;
      tap_state       = TapRunTestIdle;
   endtask

   task automatic accept(input int idx);
      dr_if.upd_ready      = '0;
      dr_if.upd_ready[idx] = 1'b1;
      tick();
      dr_if.upd_ready = '0;
   endtask

   task automatic test_reset();
      trst = 1'b1;
      tick();
      tick();
      tick();
      trst = 1'b0;
      n_checks++;
      if (dr_if.upd_valid !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_valid: got %h expected 00", dr_if.upd_valid);
      end
      n_checks++;
      if (dr_if.upd_data !== 256'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 0", dr_if.upd_data);
      end
      n_checks++;
      if ({len_err_o, overrun_o, tdo} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got len/ovr/tdo=%b expected 000",
                  {len_err_o, overrun_o, tdo});
      end
   endtask

   task automatic test_capture_shift();
      logic [31:0] bits;
      logic        t;
      dr_if.cap_data[2*32 +: 32] = 32'hFFFF_FFFA;
      run_dr(3'd2, 1'b1, 32'h0000_000F, 4, 8'h00, 1'b0, bits);
      n_checks++;
      if (bits[3:0] !== 4'hA) begin
         n_fail++;
         $display("FAIL cap_tdo_seq: got %h expected a", bits[3:0]);
      end
      n_checks++;
      if (dr_if.upd_valid !== 8'h04) begin
         n_fail++;
         $display("FAIL cap_valid: got %h expected 04", dr_if.upd_valid);
      end
      n_checks++;
      if (dr_if.upd_data[2*32 +: 32] !== 32'h0000_000F) begin
         n_fail++;
         $display("FAIL cap_data: got %h expected 0000000f", dr_if.upd_data[2*32 +: 32]);
      end
      cycle(TapRunTestIdle, 1'b1, t);
      n_checks++;
      if (t !== 1'b0) begin
         n_fail++;
         $display("FAIL tdo_idle: got %b expected 0", t);
      end
      accept(2);
      n_checks++;
      if (dr_if.upd_valid !== 8'h00 || len_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL cap_accept: got valid=%h len_err=%b expected 00/0",
                  dr_if.upd_valid, len_err_o);
      end
   endtask

   task automatic test_handshake();
      logic [31:0] bits;
      dr_if.cap_data[1*32 +: 32] = 32'h1234_5678;
      run_dr(3'd1, 1'b1, 32'hDEAD_BEEF, 32, 8'h00, 1'b0, bits);
      n_checks++;
      if (bits !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL hs_tdo_capture: got %h expected 12345678", bits);
      end
      n_checks++;
      if (dr_if.upd_valid !== 8'h02 || dr_if.upd_data[1*32 +: 32] !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL hs_update: got valid=%h data=%h expected 02/deadbeef",
                  dr_if.upd_valid, dr_if.upd_data[1*32 +: 32]);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (dr_if.upd_valid[1] !== 1'b1 || dr_if.upd_data[1*32 +: 32] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL hs_hold%0d: got valid=%b data=%h expected 1/deadbeef",
                     c, dr_if.upd_valid[1], dr_if.upd_data[1*32 +: 32]);
         end
      end
      accept(1);
      n_checks++;
      if (dr_if.upd_valid !== 8'h00 || dr_if.upd_data[1*32 +: 32] !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL hs_accept: got valid=%h data=%h expected 00/deadbeef",
                  dr_if.upd_valid, dr_if.upd_data[1*32 +: 32]);
      end
      accept(3);
      n_checks++;
      if (dr_if.upd_valid !== 8'h00) begin
         n_fail++;
         $display("FAIL hs_idle_ready: got %h expected 00", dr_if.upd_valid);
      end
   endtask

   task automatic test_len_err();
      logic [31:0] bits;
      run_dr(3'd0, 1'b1, 32'h7FFF_FFFF, 31, 8'h00, 1'b0, bits);
      n_checks++;
      if (len_err_o !== 1'b1 || dr_if.upd_valid[0] !== 1'b0 || overrun_o !== 1'b0) begin
         n_fail++;
         $display("FAIL len_err_set: got len=%b valid0=%b ovr=%b expected 1/0/0",
                  len_err_o, dr_if.upd_valid[0], overrun_o);
      end
      clr_err_i = 1'b1;
      tick();
      clr_err_i = 1'b0;
      n_checks++;
      if (len_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL len_err_clr: got %b expected 0", len_err_o);
      end
      run_dr(3'd0, 1'b1, 32'h0, 5, 8'h00, 1'b1, bits);
      n_checks++;
      if (len_err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL len_err_clr_collide: got %b expected 1", len_err_o);
      end
      clr_err_i = 1'b1;
      tick();
      clr_err_i = 1'b0;
   endtask

   task automatic test_overrun();
      logic [31:0] bits;
      run_dr(3'd1, 1'b1, 32'h1111_1111, 32, 8'h00, 1'b0, bits);
      run_dr(3'd1, 1'b1, 32'h2222_2222, 32, 8'h00, 1'b0, bits);
      n_checks++;
      if (overrun_o !== 1'b1 || dr_if.upd_valid !== 8'h02 ||
          dr_if.upd_data[1*32 +: 32] !== 32'h1111_1111) begin
         n_fail++;
         $display("FAIL overrun: got ovr=%b valid=%h data=%h expected 1/02/11111111",
                  overrun_o, dr_if.upd_valid, dr_if.upd_data[1*32 +: 32]);
      end
      accept(1);
      clr_err_i = 1'b1;
      tick();
      clr_err_i = 1'b0;
      n_checks++;
      if (overrun_o !== 1'b0 || dr_if.upd_valid !== 8'h00) begin
         n_fail++;
         $display("FAIL overrun_clr: got ovr=%b valid=%h expected 0/00",
                  overrun_o, dr_if.upd_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] bits;
      run_dr(3'd1, 1'b1, 32'hAAAA_5555, 32, 8'h00, 1'b0, bits);
      run_dr(3'd1, 1'b1, 32'h0F0F_0F0F, 32, 8'h02, 1'b0, bits);
      n_checks++;
      if (dr_if.upd_valid !== 8'h02 || overrun_o !== 1'b0 ||
          dr_if.upd_data[1*32 +: 32] !== 32'h0F0F_0F0F) begin
         n_fail++;
         $display("FAIL b2b: got valid=%h ovr=%b data=%h expected 02/0/0f0f0f0f",
                  dr_if.upd_valid, overrun_o, dr_if.upd_data[1*32 +: 32]);
      end
      accept(1);
   endtask

   task automatic test_bypass();
      logic [31:0] bits;
      run_dr(3'd1, 1'b0, 32'h0000_005A, 9, 8'h00, 1'b0, bits);
      n_checks++;
      if (bits[8:0] !== 9'h0B4) begin
         n_fail++;
         $display("FAIL bypass_tdo: got %h expected 0b4", bits[8:0]);
      end
      n_checks++;
      if (dr_if.upd_valid !== 8'h00 || len_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL bypass_noupd: got valid=%h len=%b expected 00/0",
                  dr_if.upd_valid, len_err_o);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] bits;
      run_dr(3'd3, 1'b1, 32'h0000_00C3, 8, 8'h00, 1'b0, bits);
      n_checks++;
      if (dr_if.upd_valid !== 8'h08 || dr_if.upd_data[3*32 +: 32] !== 32'h0000_00C3) begin
         n_fail++;
         $display("FAIL mid_update: got valid=%h data=%h expected 08/000000c3",
                  dr_if.upd_valid, dr_if.upd_data[3*32 +: 32]);
      end
      trst = 1'b1;
      tick();
      trst = 1'b0;
      n_checks++;
      if (dr_if.upd_valid !== 8'h00 || dr_if.upd_data[3*32 +: 32] !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_reset: got valid=%h data=%h expected 00/0",
                  dr_if.upd_valid, dr_if.upd_data[3*32 +: 32]);
      end
   endtask

`ifdef JTAG_DR_AUTOINC_EN
   task automatic test_autoinc();
      logic [31:0] bits;
      run_dr(3'd0, 1'b1, 32'h0000_1000, 32, 8'h00, 1'b0, bits);
      accept(0);
      for (int j = 0; j < 3; j++) begin
         run_dr(3'd1, 1'b1, 32'(j), 32, 8'h00, 1'b0, bits);
         accept(1);
      end
      n_checks++;
      if (dr_if.upd_data[0 +: 32] !== 32'h0000_100C || dr_if.upd_valid !== 8'h00) begin
         n_fail++;
         $display("FAIL autoinc_step: got addr=%h valid=%h expected 0000100c/00",
                  dr_if.upd_data[0 +: 32], dr_if.upd_valid);
      end
      run_dr(3'd0, 1'b1, 32'hFFFF_FFFC, 32, 8'h00, 1'b0, bits);
      accept(0);
      run_dr(3'd1, 1'b1, 32'h5, 32, 8'h00, 1'b0, bits);
      accept(1);
      n_checks++;
      if (dr_if.upd_data[0 +: 32] !== 32'h0) begin
         n_fail++;
         $display("FAIL autoinc_wrap: got %h expected 0", dr_if.upd_data[0 +: 32]);
      end
   endtask
`endif

   initial begin
      trst            = 1'b1;
      tdi             = 1'b0;
      tap_state       = TapTestLogicReset;
      dr_sel          = '0;
      dr_sel_vld      = 1'b0;
      clr_err_i       = 1'b0;
      dr_if.cap_data  = '0;
      dr_if.upd_ready = '0;
      test_reset();
      tap_state = TapRunTestIdle;
      tick();
      test_capture_shift();
      test_handshake();
      test_len_err();
      test_overrun();
      test_back_to_back();
      test_bypass();
      test_reset_mid();
`ifdef JTAG_DR_AUTOINC_EN
      test_autoinc();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
